// File: rtl/timer_bank.sv
// Multi-channel cycle timer: per-channel start/end measurement with pause, accumulate,
// saturation, completed-run counting and a registered select-mux readout.
module timer_bank #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned RUN_W  = 8,
    parameter int unsigned SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] i_start,
    input  logic [NUM_CH-1:0] i_end,
    input  logic [NUM_CH-1:0] i_pause,
    input  logic              i_accum,
    input  logic              i_clear,
    input  logic [SEL_W-1:0]  i_sel,
    output logic [CNT_W-1:0]  o_time,
    output logic [RUN_W-1:0]  o_runs,
    output logic [NUM_CH-1:0] o_running,
    output logic [NUM_CH-1:0] o_valid,
    output logic [NUM_CH-1:0] o_done,
    output logic [NUM_CH-1:0] o_sat
);

    typedef enum logic [1:0] {StIdle, StRun, StStopped} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [RUN_W-1:0] RunMax = '1;

    state_e            r_state  [NUM_CH];
    state_e            w_state_d[NUM_CH];
    logic [CNT_W-1:0]  r_cnt    [NUM_CH];
    logic [CNT_W-1:0]  w_cnt_d  [NUM_CH];
    logic [RUN_W-1:0]  r_runs   [NUM_CH];
    logic [RUN_W-1:0]  w_runs_d [NUM_CH];
    logic [NUM_CH-1:0] r_done, w_done_d;
    logic [NUM_CH-1:0] r_sat, w_sat_d;
    logic [CNT_W-1:0]  r_time, w_time;
    logic [RUN_W-1:0]  r_runs_out, w_runs_out;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_state_d[c] = r_state[c];
            w_cnt_d[c]   = r_cnt[c];
            w_runs_d[c]  = r_runs[c];
            w_done_d[c]  = 1'b0;
            w_sat_d[c]   = r_sat[c];
            if (i_clear) begin
                w_state_d[c] = StIdle;
                w_cnt_d[c]   = '0;
                w_runs_d[c]  = '0;
                w_sat_d[c]   = 1'b0;
            end else begin
                unique case (r_state[c])
                    StIdle, StStopped: begin
                        if (i_start[c]) begin
                            w_state_d[c] = StRun;
                            if (i_accum) begin
                                w_cnt_d[c] = (r_cnt[c] == CntMax) ? r_cnt[c] : r_cnt[c] + 1'b1;
                            end else begin
                                w_cnt_d[c] = CNT_W'(1);
                            end
                        end
                    end
                    StRun: begin
                        // End cycle is not counted; start/pause are don't-care here.
                        if (i_end[c]) begin
                            w_state_d[c] = StStopped;
                            w_done_d[c]  = 1'b1;
                            w_runs_d[c]  = (r_runs[c] == RunMax) ? r_runs[c] : r_runs[c] + 1'b1;
                        end else if (!i_pause[c] && r_cnt[c] != CntMax) begin
                            w_cnt_d[c] = r_cnt[c] + 1'b1;
                        end
                    end
                    default: w_state_d[c] = StIdle;
                endcase
                if (w_cnt_d[c] == CntMax) begin
                    w_sat_d[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_time     = '0;
        w_runs_out = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (i_sel == SEL_W'(c)) begin
                w_time     = r_cnt[c];
                w_runs_out = r_runs[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c] <= StIdle;
                r_cnt[c]   <= '0;
                r_runs[c]  <= '0;
            end
            r_done     <= '0;
            r_sat      <= '0;
            r_time     <= '0;
            r_runs_out <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c] <= w_state_d[c];
                r_cnt[c]   <= w_cnt_d[c];
                r_runs[c]  <= w_runs_d[c];
            end
            r_done     <= w_done_d;
            r_sat      <= w_sat_d;
            r_time     <= w_time;
            r_runs_out <= w_runs_out;
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            o_running[c] = (r_state[c] == StRun);
            o_valid[c]   = (r_state[c] == StStopped);
        end
    end

    assign o_time = r_time;
    assign o_runs = r_runs_out;
    assign o_done = r_done;
    assign o_sat  = r_sat;

endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: directed scenarios plus randomized traffic, all checked against a
// per-channel arithmetic model of run/stop timing.
module tb_timer_bank;

    localparam int NCH  = 4;
    localparam int CW   = 4;
    localparam int RW   = 3;
    localparam int SW   = 3;
    localparam int MAXC = (1 << CW) - 1;
    localparam int MAXR = (1 << RW) - 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] i_start, i_end, i_pause;
    logic           i_accum, i_clear;
    logic [SW-1:0]  i_sel;
    logic [CW-1:0]  o_time;
    logic [RW-1:0]  o_runs;
    logic [NCH-1:0] o_running, o_valid, o_done, o_sat;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: a channel is either running or not; valid means it has finished a run.
    int m_cnt [NCH];
    int m_runs[NCH];
    bit m_run [NCH];
    bit m_val [NCH];
    bit m_done[NCH];
    bit m_sat [NCH];
    int m_time, m_runs_out;

    timer_bank #(.NUM_CH(NCH), .CNT_W(CW), .RUN_W(RW), .SEL_W(SW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (i_start),
        .i_end    (i_end),
        .i_pause  (i_pause),
        .i_accum  (i_accum),
        .i_clear  (i_clear),
        .i_sel    (i_sel),
        .o_time   (o_time),
        .o_runs   (o_runs),
        .o_running(o_running),
        .o_valid  (o_valid),
        .o_done   (o_done),
        .o_sat    (o_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_runs[c] = 0; m_run[c] = 0;
            m_val[c] = 0; m_done[c] = 0; m_sat[c] = 0;
        end
        m_time = 0;
        m_runs_out = 0;
    endtask

    task automatic check_all(input string tag);
        logic [NCH-1:0] e_run, e_val, e_done, e_sat;
        for (int c = 0; c < NCH; c++) begin
            e_run[c] = m_run[c]; e_val[c] = m_val[c];
            e_done[c] = m_done[c]; e_sat[c] = m_sat[c];
        end
        chk({tag, ".running"}, 32'(o_running), 32'(e_run));
        chk({tag, ".valid"},   32'(o_valid),   32'(e_val));
        chk({tag, ".done"},    32'(o_done),    32'(e_done));
        chk({tag, ".sat"},     32'(o_sat),     32'(e_sat));
        chk({tag, ".time"},    32'(o_time),    32'(m_time));
        chk({tag, ".runs"},    32'(o_runs),    32'(m_runs_out));
    endtask

    // One clock: drive inputs after the falling edge, advance the model, check after the rise.
    task automatic step(input logic [NCH-1:0] st, input logic [NCH-1:0] en,
                        input logic [NCH-1:0] pa, input logic ac, input logic cl,
                        input logic [SW-1:0] sel, input string tag);
        i_start = st; i_end = en; i_pause = pa;
        i_accum = ac; i_clear = cl; i_sel = sel;
        m_time     = (int'(sel) < NCH) ? m_cnt[sel] : 0;
        m_runs_out = (int'(sel) < NCH) ? m_runs[sel] : 0;
        for (int c = 0; c < NCH; c++) begin
            if (cl) begin
                m_cnt[c] = 0; m_runs[c] = 0; m_run[c] = 0;
                m_val[c] = 0; m_done[c] = 0; m_sat[c] = 0;
            end else begin
                m_done[c] = 0;
                if (!m_run[c]) begin
                    if (st[c]) begin
                        m_run[c] = 1;
                        m_val[c] = 0;
                        m_cnt[c] = ac ? ((m_cnt[c] + 1 > MAXC) ? MAXC : m_cnt[c] + 1) : 1;
                    end
                end else if (en[c]) begin
                    m_run[c]  = 0;
                    m_val[c]  = 1;
                    m_done[c] = 1;
                    m_runs[c] = (m_runs[c] + 1 > MAXR) ? MAXR : m_runs[c] + 1;
                end else if (!pa[c]) begin
                    m_cnt[c] = (m_cnt[c] + 1 > MAXC) ? MAXC : m_cnt[c] + 1;
                end
                if (m_cnt[c] == MAXC) m_sat[c] = 1;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ac, input logic [SW-1:0] sel, input string tag);
        for (int k = 0; k < n; k++) step('0, '0, '0, ac, 1'b0, sel, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        i_start = '0; i_end = '0; i_pause = '0;
        i_accum = 1'b0; i_clear = 1'b0; i_sel = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic timing on ch0, mode 0.
        idle(10, 1'b0, 3'd0, "pre");
        step(4'b0001, '0, '0, 1'b0, 1'b0, 3'd0, "b_start");
        idle(9, 1'b0, 3'd0, "b_run");
        step('0, 4'b0001, '0, 1'b0, 1'b0, 3'd0, "b_end");
        chk("basic_time", 32'(o_time), 32'd10);
        chk("basic_done", 32'(o_done[0]), 32'd1);
        chk("basic_valid", 32'(o_valid[0]), 32'd1);
        idle(1, 1'b0, 3'd0, "b_post");
        chk("basic_runs", 32'(o_runs), 32'd1);
        chk("basic_done_low", 32'(o_done[0]), 32'd0);
        step(4'b0001, '0, '0, 1'b0, 1'b0, 3'd0, "b_restart");
        idle(1, 1'b0, 3'd0, "b_restart_rd");
        chk("restart_time", 32'(o_time), 32'd1);

        // Pause on ch1; a start while running is ignored.
        step(4'b0010, '0, '0, 1'b0, 1'b0, 3'd1, "p_start");
        idle(2, 1'b0, 3'd1, "p_run");
        step('0, '0, 4'b0010, 1'b0, 1'b0, 3'd1, "p_pause3");
        step('0, '0, 4'b0010, 1'b0, 1'b0, 3'd1, "p_pause4");
        step(4'b0010, '0, 4'b0010, 1'b0, 1'b0, 3'd1, "p_pause5");
        step('0, '0, 4'b0010, 1'b0, 1'b0, 3'd1, "p_pause6");
        step('0, '0, 4'b0010, 1'b0, 1'b0, 3'd1, "p_pause7");
        idle(4, 1'b0, 3'd1, "p_run2");
        step('0, 4'b0010, '0, 1'b0, 1'b0, 3'd1, "p_end");
        chk("pause_time", 32'(o_time), 32'd7);

        // Accumulate across two runs on ch2.
        step(4'b0100, '0, '0, 1'b1, 1'b0, 3'd2, "a_start1");
        idle(4, 1'b1, 3'd2, "a_run1");
        step('0, 4'b0100, '0, 1'b1, 1'b0, 3'd2, "a_end1");
        idle(10, 1'b1, 3'd2, "a_gap");
        step(4'b0100, '0, '0, 1'b1, 1'b0, 3'd2, "a_start2");
        idle(2, 1'b1, 3'd2, "a_run2");
        step('0, 4'b0100, '0, 1'b1, 1'b0, 3'd2, "a_end2");
        idle(1, 1'b1, 3'd2, "a_rd");
        chk("accum_time", 32'(o_time), 32'd8);
        chk("accum_runs", 32'(o_runs), 32'd2);

        // Saturation on ch3.
        step(4'b1000, '0, '0, 1'b0, 1'b0, 3'd3, "s_start");
        idle(13, 1'b0, 3'd3, "s_run");
        chk("sat_before", 32'(o_sat[3]), 32'd0);
        idle(1, 1'b0, 3'd3, "s_hit");
        chk("sat_at_max", 32'(o_sat[3]), 32'd1);
        idle(5, 1'b0, 3'd3, "s_stick");
        step('0, 4'b1000, '0, 1'b0, 1'b0, 3'd3, "s_end");
        idle(1, 1'b0, 3'd3, "s_rd");
        chk("sat_time", 32'(o_time), 32'd15);
        step(4'b1000, '0, '0, 1'b0, 1'b0, 3'd3, "s_restart");
        idle(1, 1'b0, 3'd3, "s_restart_rd");
        chk("sat_restart_time", 32'(o_time), 32'd1);
        chk("sat_sticky", 32'(o_sat[3]), 32'd1);

        // Start and end together in a non-running state.
        step('0, 4'b0001, '0, 1'b0, 1'b0, 3'd0, "q_end0");
        step(4'b0001, 4'b0001, '0, 1'b0, 1'b0, 3'd0, "q_se");
        chk("se_running", 32'(o_running[0]), 32'd1);
        idle(1, 1'b0, 3'd0, "q_se_rd");
        chk("se_time", 32'(o_time), 32'd1);

        // Global clear during activity on all channels.
        step(4'b1111, '0, '0, 1'b0, 1'b0, 3'd3, "c_start");
        idle(3, 1'b0, 3'd3, "c_run");
        step('0, '0, '0, 1'b0, 1'b1, 3'd3, "c_clear");
        chk("clear_running", 32'(o_running), 32'd0);
        chk("clear_sat", 32'(o_sat), 32'd0);
        idle(1, 1'b0, 3'd3, "c_rd");
        chk("clear_time", 32'(o_time), 32'd0);

        // Out-of-range select.
        step(4'b0001, '0, '0, 1'b0, 1'b0, 3'd4, "o_start");
        idle(3, 1'b0, 3'd4, "o_run");
        chk("oob_time", 32'(o_time), 32'd0);

        // Asynchronous reset in the middle of a run.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_running", 32'(o_running), 32'd0);
        chk("arst_time", 32'(o_time), 32'd0);
        chk("arst_sat", 32'(o_sat), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3, 1'b0, 3'd0, "arst_idle");
        step(4'b0001, '0, '0, 1'b0, 1'b0, 3'd0, "arst_start");
        idle(2, 1'b0, 3'd0, "arst_run");

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            logic [NCH-1:0] st, en, pa;
            logic ac, cl;
            logic [SW-1:0] sel;
            for (int c = 0; c < NCH; c++) begin
                st[c] = ($urandom_range(3) == 0);
                en[c] = ($urandom_range(3) == 0);
                pa[c] = ($urandom_range(3) == 0);
            end
            ac  = ((k / 25) % 2) == 1;
            cl  = ($urandom_range(59) == 0);
            sel = 3'($urandom_range(4));
            step(st, en, pa, ac, cl, sel, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
